// File: rtl/lcd_spi_rx_pkg.sv
// Shared definitions for the LCD SPI receiver: command opcodes, decode FSM encodings
// and small byte helpers. The LCD driver and the bench import the same package.
package lcd_spi_rx_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [2:0] LAST_BIT = 3'd7;

    // Decode FSM encodings; CASET/RASET carry the index of the next expected parameter byte
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CASET0   = 4'd1;
    localparam logic [3:0] ST_CASET1   = 4'd2;
    localparam logic [3:0] ST_CASET2   = 4'd3;
    localparam logic [3:0] ST_CASET3   = 4'd4;
    localparam logic [3:0] ST_RASET0   = 4'd5;
    localparam logic [3:0] ST_RASET1   = 4'd6;
    localparam logic [3:0] ST_RASET2   = 4'd7;
    localparam logic [3:0] ST_RASET3   = 4'd8;
    localparam logic [3:0] ST_RAMWR_HI = 4'd9;
    localparam logic [3:0] ST_RAMWR_LO = 4'd10;

    function automatic logic [15:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/lcd_spi_deser.sv
// LCD SPI deserialiser: synchronises the bus pins into the system clock domain,
// detects sclk rising edges while cs is low and assembles MSB-first bytes.
module lcd_spi_deser
    import lcd_spi_rx_pkg::*;
#(
    parameter int SYNC_STG = 2
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rst_n,
    input  logic       cs,
    input  logic       dc,
    input  logic       sclk,
    input  logic       mosi,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       byte_valid,
    output logic       lcd_run
);

    logic [SYNC_STG-1:0] cs_sync;
    logic [SYNC_STG-1:0] dc_sync;
    logic [SYNC_STG-1:0] sclk_sync;
    logic [SYNC_STG-1:0] mosi_sync;
    logic [SYNC_STG-1:0] rst_sync;

    logic       cs_s;
    logic       dc_s;
    logic       sclk_s;
    logic       mosi_s;
    logic       sclk_prev;
    logic       rise;
    logic [2:0] bit_count;
    logic [6:0] shift;
    logic       dc_latch;

    // The LCD reset pin synchroniser starts asserted so the decoder stays cleared until it settles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            dc_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            rst_sync  <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STG-2:0], cs};
            dc_sync   <= {dc_sync[SYNC_STG-2:0], dc};
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], mosi};
            rst_sync  <= {rst_sync[SYNC_STG-2:0], lcd_rst_n};
        end
    end

    assign cs_s    = cs_sync[SYNC_STG-1];
    assign dc_s    = dc_sync[SYNC_STG-1];
    assign sclk_s  = sclk_sync[SYNC_STG-1];
    assign mosi_s  = mosi_sync[SYNC_STG-1];
    assign lcd_run = rst_sync[SYNC_STG-1];
    assign rise    = sclk_s & ~sclk_prev & ~cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
        end
    end

    // Deasserted cs or LCD reset drops any partial byte; dc is captured with the first (MSB) bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count  <= '0;
            shift      <= '0;
            dc_latch   <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
            byte_valid <= 1'b0;
        end else if (!lcd_run || cs_s) begin
            bit_count  <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (rise) begin
                shift     <= {shift[5:0], mosi_s};
                bit_count <= bit_count + 3'd1;
                if (bit_count == 3'd0) begin
                    dc_latch <= dc_s;
                end
                if (bit_count == LAST_BIT) begin
                    byte_data  <= {shift, mosi_s};
                    byte_dc    <= dc_latch;
                    byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_rx.sv
// Receive side of the 4-wire SPI LCD link: decodes CASET/RASET/RAMWR into addressed RGB565 pixels.
// Define LCD_RX_FRAME_EN to add o_frame_done, pulsed with the pixel written at (xe,ye).
module lcd_spi_rx
    import lcd_spi_rx_pkg::*;
#(
    parameter int COORD_W  = 9,
    parameter int SYNC_STG = 2
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_lcd_rst_n,
    input  logic               i_cs,
    input  logic               i_dc,
    input  logic               i_sclk,
    input  logic               i_mosi,
    output logic [7:0]         o_cmd,
    output logic               o_cmd_valid,
    output logic               o_pix_valid,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic [15:0]        o_pix_data
`ifdef LCD_RX_FRAME_EN
    ,
    output logic               o_frame_done
`endif
);

    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       rx_valid;
    logic       lcd_run;

    lcd_spi_deser #(
        .SYNC_STG (SYNC_STG)
    ) u_deser (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .lcd_rst_n  (i_lcd_rst_n),
        .cs         (i_cs),
        .dc         (i_dc),
        .sclk       (i_sclk),
        .mosi       (i_mosi),
        .byte_data  (rx_byte),
        .byte_dc    (rx_dc),
        .byte_valid (rx_valid),
        .lcd_run    (lcd_run)
    );

    logic [3:0]         state;
    logic [7:0]         param0;
    logic [7:0]         param1;
    logic [7:0]         param2;
    logic [7:0]         pix_hi;
    logic [COORD_W-1:0] xs;
    logic [COORD_W-1:0] xe;
    logic [COORD_W-1:0] ys;
    logic [COORD_W-1:0] ye;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic [COORD_W-1:0] win_start;
    logic [COORD_W-1:0] win_end;

    // Window walk; when end < start the natural modulo wrap of the counters reaches the end value
    always_comb begin
        x_next = x + 1'b1;
        y_next = y;
        if (x == xe) begin
            x_next = xs;
            y_next = (y == ye) ? ys : y + 1'b1;
        end
    end

    assign win_start = COORD_W'(join_bytes(param0, param1));
    assign win_end   = COORD_W'(join_bytes(param2, rx_byte));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            param0      <= '0;
            param1      <= '0;
            param2      <= '0;
            pix_hi      <= '0;
            xs          <= '0;
            xe          <= '0;
            ys          <= '0;
            ye          <= '0;
            x           <= '0;
            y           <= '0;
            o_cmd       <= '0;
            o_cmd_valid <= 1'b0;
            o_pix_valid <= 1'b0;
            o_pix_x     <= '0;
            o_pix_y     <= '0;
            o_pix_data  <= '0;
`ifdef LCD_RX_FRAME_EN
            o_frame_done <= 1'b0;
`endif
        end else if (!lcd_run) begin
            state       <= ST_IDLE;
            param0      <= '0;
            param1      <= '0;
            param2      <= '0;
            pix_hi      <= '0;
            xs          <= '0;
            xe          <= '0;
            ys          <= '0;
            ye          <= '0;
            x           <= '0;
            y           <= '0;
            o_cmd       <= '0;
            o_cmd_valid <= 1'b0;
            o_pix_valid <= 1'b0;
            o_pix_x     <= '0;
            o_pix_y     <= '0;
            o_pix_data  <= '0;
`ifdef LCD_RX_FRAME_EN
            o_frame_done <= 1'b0;
`endif
        end else begin
            o_cmd_valid <= 1'b0;
            o_pix_valid <= 1'b0;
`ifdef LCD_RX_FRAME_EN
            o_frame_done <= 1'b0;
`endif
            if (rx_valid && !rx_dc) begin
                // A command always aborts whatever sequence was in progress
                o_cmd       <= rx_byte;
                o_cmd_valid <= 1'b1;
                case (rx_byte)
                    CMD_CASET: state <= ST_CASET0;
                    CMD_RASET: state <= ST_RASET0;
                    CMD_RAMWR: begin
                        state <= ST_RAMWR_HI;
                        x     <= xs;
                        y     <= ys;
                    end
                    default:   state <= ST_IDLE;
                endcase
            end else if (rx_valid) begin
                case (state)
                    ST_CASET0: begin param0 <= rx_byte; state <= ST_CASET1; end
                    ST_CASET1: begin param1 <= rx_byte; state <= ST_CASET2; end
                    ST_CASET2: begin param2 <= rx_byte; state <= ST_CASET3; end
                    ST_CASET3: begin
                        xs    <= win_start;
                        xe    <= win_end;
                        state <= ST_IDLE;
                    end
                    ST_RASET0: begin param0 <= rx_byte; state <= ST_RASET1; end
                    ST_RASET1: begin param1 <= rx_byte; state <= ST_RASET2; end
                    ST_RASET2: begin param2 <= rx_byte; state <= ST_RASET3; end
                    ST_RASET3: begin
                        ys    <= win_start;
                        ye    <= win_end;
                        state <= ST_IDLE;
                    end
                    ST_RAMWR_HI: begin
                        pix_hi <= rx_byte;
                        state  <= ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        o_pix_valid <= 1'b1;
                        o_pix_x     <= x;
                        o_pix_y     <= y;
                        o_pix_data  <= join_bytes(pix_hi, rx_byte);
`ifdef LCD_RX_FRAME_EN
                        o_frame_done <= (x == xe) && (y == ye);
`endif
                        x     <= x_next;
                        y     <= y_next;
                        state <= ST_RAMWR_HI;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Scoreboard bench for lcd_spi_rx: directed SPI sequences plus randomised traffic, checked
// against a transaction-level display model; honours LCD_RX_FRAME_EN for o_frame_done.
module tb_lcd_spi_rx;
    import lcd_spi_rx_pkg::*;

    localparam int COORD_W  = 9;
    localparam int SYNC_STG = 2;
    localparam int MASK     = (1 << COORD_W) - 1;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_lcd_rst_n = 1'b1;
    logic               i_cs = 1'b1;
    logic               i_dc = 1'b0;
    logic               i_sclk = 1'b0;
    logic               i_mosi = 1'b0;
    logic [7:0]         o_cmd;
    logic               o_cmd_valid;
    logic               o_pix_valid;
    logic [COORD_W-1:0] o_pix_x;
    logic [COORD_W-1:0] o_pix_y;
    logic [15:0]        o_pix_data;
`ifdef LCD_RX_FRAME_EN
    logic               o_frame_done;
`endif

    lcd_spi_rx #(
        .COORD_W  (COORD_W),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lcd_rst_n (i_lcd_rst_n),
        .i_cs        (i_cs),
        .i_dc        (i_dc),
        .i_sclk      (i_sclk),
        .i_mosi      (i_mosi),
        .o_cmd       (o_cmd),
        .o_cmd_valid (o_cmd_valid),
        .o_pix_valid (o_pix_valid),
        .o_pix_x     (o_pix_x),
        .o_pix_y     (o_pix_y),
        .o_pix_data  (o_pix_data)
`ifdef LCD_RX_FRAME_EN
        ,
        .o_frame_done (o_frame_done)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int x;
        int y;
        int data;
        bit frame;
    } pix_t;

    int       checks = 0;
    int       fails = 0;
    int       cyc = 0;
    int       last_rise = 0;
    logic [7:0] cmd_q[$];
    pix_t     pix_q[$];
    logic [8:0] byte_q[$];

    // Display model state: window, write cursor and the command currently collecting bytes
    int       mode = 0;
    int       params[$];
    bit       have_hi = 0;
    int       hi_byte = 0;
    int       win_xs = 0, win_xe = 0, win_ys = 0, win_ye = 0;
    int       cur_x = 0, cur_y = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void stray(string name, logic [31:0] act);
        checks++;
        fails++;
        $display("[TB] FAIL %s: unexpected strobe with value 0x%0h, expected none", name, act);
    endfunction

    function automatic void model_reset();
        mode = 0;
        params.delete();
        have_hi = 0;
        win_xs = 0; win_xe = 0; win_ys = 0; win_ye = 0;
        cur_x = 0; cur_y = 0;
    endfunction

    function automatic void model_byte(bit dc, logic [7:0] b);
        pix_t p;
        int   s;
        int   e;
        byte_q.push_back({dc, b});
        if (!dc) begin
            cmd_q.push_back(b);
            params.delete();
            have_hi = 0;
            if (b == 8'h2A) mode = 1;
            else if (b == 8'h2B) mode = 2;
            else if (b == 8'h2C) begin
                mode = 3;
                cur_x = win_xs;
                cur_y = win_ys;
            end else mode = 0;
        end else if (mode == 1 || mode == 2) begin
            params.push_back(int'(b));
            if (params.size() == 4) begin
                s = ((params[0] * 256) + params[1]) & MASK;
                e = ((params[2] * 256) + params[3]) & MASK;
                if (mode == 1) begin win_xs = s; win_xe = e; end
                else begin win_ys = s; win_ye = e; end
                params.delete();
                mode = 0;
            end
        end else if (mode == 3) begin
            if (!have_hi) begin
                hi_byte = int'(b);
                have_hi = 1;
            end else begin
                p.x = cur_x;
                p.y = cur_y;
                p.data = hi_byte * 256 + int'(b);
                p.frame = (cur_x == win_xe) && (cur_y == win_ye);
                pix_q.push_back(p);
                have_hi = 0;
                if (cur_x == win_xe) begin
                    cur_x = win_xs;
                    cur_y = (cur_y == win_ye) ? win_ys : ((cur_y + 1) & MASK);
                end else begin
                    cur_x = (cur_x + 1) & MASK;
                end
            end
        end
    endfunction

    // Drives nbits of a byte MSB first with sclk at i_clk/4; only complete bytes reach the model
    task send_bits(input bit dc, input logic [7:0] b, input int nbits);
        if (nbits == 8) model_byte(dc, b);
        @(negedge i_clk);
        i_cs = 1'b0;
        i_dc = dc;
        for (int i = 0; i < nbits; i++) begin
            i_mosi = b[7 - i];
            repeat (2) @(negedge i_clk);
            i_sclk = 1'b1;
            last_rise = cyc;
            repeat (2) @(negedge i_clk);
            i_sclk = 1'b0;
        end
    endtask

    task send_byte(input bit dc, input logic [7:0] b);
        send_bits(dc, b, 8);
    endtask

    task send_pixel(input logic [15:0] d);
        send_byte(1'b1, d[15:8]);
        send_byte(1'b1, d[7:0]);
    endtask

    task cs_gap(input int n);
        i_cs = 1'b1;
        repeat (n) @(negedge i_clk);
    endtask

    task send_random_byte(input bit dc, input logic [7:0] b);
        send_byte(dc, b);
        if ($urandom_range(0, 3) == 0) cs_gap($urandom_range(1, 6));
    endtask

    pix_t       mon_pix;
    logic [8:0] mon_byte;

    always @(negedge i_clk) begin
        if (o_cmd_valid) begin
            if (cmd_q.size() == 0) stray("cmd_valid", 32'(o_cmd));
            else check_output("cmd", 32'(o_cmd), 32'(cmd_q.pop_front()));
        end
        if (o_pix_valid) begin
            if (pix_q.size() == 0) stray("pix_valid", 32'(o_pix_data));
            else begin
                mon_pix = pix_q.pop_front();
                check_output("pix_x", 32'(o_pix_x), mon_pix.x);
                check_output("pix_y", 32'(o_pix_y), mon_pix.y);
                check_output("pix_data", 32'(o_pix_data), mon_pix.data);
`ifdef LCD_RX_FRAME_EN
                check_output("frame_done", 32'(o_frame_done), 32'(mon_pix.frame));
`endif
            end
        end
`ifdef LCD_RX_FRAME_EN
        if (o_frame_done && !o_pix_valid) stray("frame_done", 32'(o_frame_done));
`endif
        if (dut.u_deser.byte_valid) begin
            if (byte_q.size() == 0) stray("byte_valid", 32'({dut.u_deser.byte_dc, dut.u_deser.byte_data}));
            else begin
                mon_byte = byte_q.pop_front();
                check_output("byte_log", 32'({dut.u_deser.byte_dc, dut.u_deser.byte_data}), 32'(mon_byte));
                check_output("byte_latency", 32'(cyc - last_rise), SYNC_STG + 1);
            end
        end
    end

    initial begin
        // Reset held while the bus toggles: nothing may be captured
        i_cs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk);
            i_sclk = ~i_sclk;
            i_mosi = 1'($urandom_range(0, 1));
        end
        i_cs = 1'b1;
        i_sclk = 1'b0;
        @(negedge i_clk);
        check_output("rst_cmd", 32'(o_cmd), 0);
        check_output("rst_cmd_valid", 32'(o_cmd_valid), 0);
        check_output("rst_pix_valid", 32'(o_pix_valid), 0);
        check_output("rst_pix_x", 32'(o_pix_x), 0);
        check_output("rst_pix_y", 32'(o_pix_y), 0);
        check_output("rst_pix_data", 32'(o_pix_data), 0);
`ifdef LCD_RX_FRAME_EN
        check_output("rst_frame_done", 32'(o_frame_done), 0);
`endif
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);

        send_byte(1'b0, 8'h11);
        cs_gap(4);

        send_byte(1'b0, CMD_CASET);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0C);
        send_byte(1'b0, CMD_RASET);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
        send_byte(1'b0, CMD_RAMWR);
        send_pixel(16'hF800); send_pixel(16'h07E0); send_pixel(16'h001F);
        send_pixel(16'hFFFF); send_pixel(16'h0000); send_pixel(16'h1234);
        send_pixel(16'hABCD);

        // Partial byte then cs release: the five bits must vanish
        send_bits(1'b1, 8'hF0, 5);
        cs_gap(6);
        send_byte(1'b1, 8'h55);
        send_byte(1'b1, 8'hAA);
        cs_gap(4);

        send_byte(1'b0, CMD_CASET);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h20);
        send_byte(1'b0, CMD_RAMWR);
        send_pixel(16'h0BAD);
        cs_gap(4);

        for (int n = 0; n < 40; n++) begin
            int k;
            int np;
            k = $urandom_range(0, 3);
            if (k < 2) begin
                send_random_byte(1'b0, (k == 0) ? CMD_CASET : CMD_RASET);
                np = $urandom_range(2, 5);
                for (int j = 0; j < np; j++)
                    send_random_byte(1'b1, (j % 2 == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 15)));
            end else if (k == 2) begin
                send_random_byte(1'b0, CMD_RAMWR);
                np = $urandom_range(0, 12);
                for (int j = 0; j < np; j++) send_random_byte(1'b1, 8'($urandom));
            end else begin
                send_random_byte(1'b0, 8'($urandom));
                np = $urandom_range(0, 3);
                for (int j = 0; j < np; j++) send_random_byte(1'b1, 8'($urandom));
            end
        end
        cs_gap(8);

        // LCD reset pin clears window and outputs just like the system reset
        i_lcd_rst_n = 1'b0;
        repeat (6) @(negedge i_clk);
        model_reset();
        check_output("lcdrst_cmd", 32'(o_cmd), 0);
        check_output("lcdrst_pix_data", 32'(o_pix_data), 0);
        check_output("lcdrst_pix_x", 32'(o_pix_x), 0);
        i_lcd_rst_n = 1'b1;
        repeat (6) @(negedge i_clk);
        send_byte(1'b0, CMD_RAMWR);
        send_pixel(16'h5A5A);
        send_pixel(16'hC3C3);
        cs_gap(4);

        for (int i = 0; i < 200 && (cmd_q.size() + pix_q.size() + byte_q.size()) != 0; i++)
            @(negedge i_clk);
        check_output("cmd_q_drained", 32'(cmd_q.size()), 0);
        check_output("pix_q_drained", 32'(pix_q.size()), 0);
        check_output("byte_q_drained", 32'(byte_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
